// File: rtl/game_pkg.sv
// Shared types, screen geometry and box-overlap helper for the per-frame game
// logic stage and its sub-blocks.
package game_pkg;

  localparam int SCREEN_W    = 640;
  localparam int SCREEN_H    = 480;
  localparam int PLAYER_HALF = 25;
  localparam int TARGET_HALF = 30;
  localparam int DEADZONE    = 4;
  localparam int VEL_SHIFT   = 3;
  localparam int MAX_TRIES   = 15;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  typedef logic [9:0]         coord_t;
  typedef logic signed [11:0] tilt_t;

  typedef enum logic [2:0] {
    ST_IDLE, ST_MOVE, ST_CLAMP, ST_CHECK, ST_RELOCATE
  } state_e;

  localparam coord_t PX_MIN   = coord_t'(PLAYER_HALF);
  localparam coord_t PX_MAX   = coord_t'(SCREEN_W - 1 - PLAYER_HALF);
  localparam coord_t PY_MIN   = coord_t'(PLAYER_HALF);
  localparam coord_t PY_MAX   = coord_t'(SCREEN_H - 1 - PLAYER_HALF);
  localparam coord_t TX_MIN   = coord_t'(TARGET_HALF);
  localparam coord_t TX_MAX   = coord_t'(SCREEN_W - 1 - TARGET_HALF);
  localparam coord_t TY_MIN   = coord_t'(TARGET_HALF);
  localparam coord_t TY_MAX   = coord_t'(SCREEN_H - 1 - TARGET_HALF);
  localparam coord_t X_LAST   = coord_t'(SCREEN_W - 1);
  localparam coord_t Y_LAST   = coord_t'(SCREEN_H - 1);
  localparam coord_t HIT_DIST = coord_t'(PLAYER_HALF + TARGET_HALF);
  localparam tilt_t  DZ       = tilt_t'(DEADZONE);
  localparam logic [3:0] LAST_TRY = 4'(MAX_TRIES - 1);

  // Boxes overlap when centres are strictly closer than the summed half-sizes.
  function automatic logic boxes_overlap(coord_t ax, coord_t ay, coord_t bx, coord_t by);
    coord_t dx, dy;
    dx = (ax > bx) ? ax - bx : bx - ax;
    dy = (ay > by) ? ay - by : by - ay;
    return (dx < HIT_DIST) && (dy < HIT_DIST);
  endfunction

  function automatic coord_t clamp_coord(logic signed [11:0] v, coord_t lo, coord_t hi);
    if (v < $signed({2'b00, lo}))      return lo;
    else if (v > $signed({2'b00, hi})) return hi;
    else                               return coord_t'(v[9:0]);
  endfunction

  function automatic logic signed [11:0] tilt_to_vel(tilt_t t);
    if (t >= -DZ && t <= DZ) return 12'sd0;
    else                     return t >>> VEL_SHIFT;
  endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11), stepping every clock.
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk_25mHz,
  input  logic        reset,
  output logic [15:0] state
);

  logic [15:0] state_q, state_d;

  always_comb begin
    state_d = {state_q[14:0], state_q[15] ^ state_q[13] ^ state_q[12] ^ state_q[10]};
  end

  // NOTE: state flops use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk_25mHz or posedge reset) begin
    if (reset) state_q <= SEED;
    else       state_q <= state_d;
  end

  assign state = state_q;

endmodule

// File: rtl/game_state_updater.sv
// Per-frame game logic: integrates tilt into player position, detects hits on the
// target, keeps score and relocates the target with LFSR rejection sampling.
module game_state_updater
  import game_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED = game_pkg::LFSR_SEED
) (
  input  logic        clk_25mHz,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic [11:0] tilt_x,
  input  logic [11:0] tilt_y,
  output logic [31:0] player_x,
  output logic [31:0] player_y,
  output logic [31:0] target_x,
  output logic [31:0] target_y,
  output logic [15:0] score,
  output logic        hit,
  output logic        busy,
  output logic        frame_overrun
);

  state_e             state_q, state_d;
  tilt_t              tilt_x_q, tilt_x_d, tilt_y_q, tilt_y_d;
  logic signed [11:0] sum_x_q, sum_x_d, sum_y_q, sum_y_d;
  coord_t             player_x_q, player_x_d, player_y_q, player_y_d;
  coord_t             target_x_q, target_x_d, target_y_q, target_y_d;
  logic [15:0]        score_q, score_d;
  logic [3:0]         tries_q, tries_d;
  logic               hit_q, hit_d, overrun_q, overrun_d;
  logic [15:0]        lfsr_q;
  coord_t             cand_x, cand_y;
  logic               cand_ok;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk_25mHz (clk_25mHz),
    .reset     (reset),
    .state     (lfsr_q)
  );

  assign cand_x  = lfsr_q[9:0];
  assign cand_y  = coord_t'({2'b00, lfsr_q[15:8]}) + coord_t'({9'd0, lfsr_q[0]});
  assign cand_ok = (cand_x >= TX_MIN) && (cand_x <= TX_MAX) &&
                   (cand_y >= TY_MIN) && (cand_y <= TY_MAX) &&
                   !boxes_overlap(cand_x, cand_y, player_x_q, player_y_q);

  always_comb begin
    // NOTE: every comb output gets a default first, so no path can infer a latch.
    state_d    = state_q;
    tilt_x_d   = tilt_x_q;
    tilt_y_d   = tilt_y_q;
    sum_x_d    = sum_x_q;
    sum_y_d    = sum_y_q;
    player_x_d = player_x_q;
    player_y_d = player_y_q;
    target_x_d = target_x_q;
    target_y_d = target_y_q;
    score_d    = score_q;
    tries_d    = tries_q;
    hit_d      = 1'b0;
    overrun_d  = frame_tick && (state_q != ST_IDLE);

    case (state_q)
      ST_IDLE: begin
        if (frame_tick) begin
          tilt_x_d = tilt_x;
          tilt_y_d = tilt_y;
          state_d  = ST_MOVE;
        end
      end
      ST_MOVE: begin
        sum_x_d = $signed({2'b00, player_x_q}) + tilt_to_vel(tilt_x_q);
        sum_y_d = $signed({2'b00, player_y_q}) + tilt_to_vel(tilt_y_q);
        state_d = ST_CLAMP;
      end
      ST_CLAMP: begin
        player_x_d = clamp_coord(sum_x_q, PX_MIN, PX_MAX);
        player_y_d = clamp_coord(sum_y_q, PY_MIN, PY_MAX);
        state_d    = ST_CHECK;
      end
      ST_CHECK: begin
        if (boxes_overlap(player_x_q, player_y_q, target_x_q, target_y_q)) begin
          hit_d   = 1'b1;
          score_d = (score_q == 16'hFFFF) ? score_q : score_q + 16'd1;
          tries_d = 4'd0;
          state_d = ST_RELOCATE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RELOCATE: begin
        if (cand_ok) begin
          target_x_d = cand_x;
          target_y_d = cand_y;
          state_d    = ST_IDLE;
        end else if (tries_q == LAST_TRY) begin
          // Out of attempts: mirror the player across the screen centre.
          target_x_d = clamp_coord($signed({2'b00, X_LAST - player_x_q}), TX_MIN, TX_MAX);
          target_y_d = clamp_coord($signed({2'b00, Y_LAST - player_y_q}), TY_MIN, TY_MAX);
          state_d    = ST_IDLE;
        end else begin
          tries_d = tries_q + 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_25mHz or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      tilt_x_q   <= '0;
      tilt_y_q   <= '0;
      sum_x_q    <= '0;
      sum_y_q    <= '0;
      player_x_q <= coord_t'(SCREEN_W / 2);
      player_y_q <= coord_t'(SCREEN_H / 2);
      target_x_q <= coord_t'(SCREEN_W / 4);
      target_y_q <= coord_t'(SCREEN_H / 4);
      score_q    <= '0;
      tries_q    <= '0;
      hit_q      <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      tilt_x_q   <= tilt_x_d;
      tilt_y_q   <= tilt_y_d;
      sum_x_q    <= sum_x_d;
      sum_y_q    <= sum_y_d;
      player_x_q <= player_x_d;
      player_y_q <= player_y_d;
      target_x_q <= target_x_d;
      target_y_q <= target_y_d;
      score_q    <= score_d;
      tries_q    <= tries_d;
      hit_q      <= hit_d;
      overrun_q  <= overrun_d;
    end
  end

  assign player_x      = {22'd0, player_x_q};
  assign player_y      = {22'd0, player_y_q};
  assign target_x      = {22'd0, target_x_q};
  assign target_y      = {22'd0, target_y_q};
  assign score         = score_q;
  assign hit           = hit_q;
  assign busy          = (state_q != ST_IDLE);
  assign frame_overrun = overrun_q;

endmodule

// File: tb/tb_game_state_updater.sv
// Self-checking bench for game_state_updater: directed corner frames plus random
// tilt frames, compared against an arithmetic model of the game rules.
module tb_game_state_updater;

  logic        clk_25mHz = 1'b0;
  logic        reset = 1'b1;
  logic        frame_tick = 1'b0;
  logic [11:0] tilt_x = '0, tilt_y = '0;
  logic [31:0] player_x, player_y, target_x, target_y;
  logic [15:0] score;
  logic        hit, busy, frame_overrun;

  int total = 0;
  int bad = 0;

  int mpx, mpy, mtx, mty, mscore;
  logic [15:0] m_lfsr;

  game_state_updater dut (
    .clk_25mHz     (clk_25mHz),
    .reset         (reset),
    .frame_tick    (frame_tick),
    .tilt_x        (tilt_x),
    .tilt_y        (tilt_y),
    .player_x      (player_x),
    .player_y      (player_y),
    .target_x      (target_x),
    .target_y      (target_y),
    .score         (score),
    .hit           (hit),
    .busy          (busy),
    .frame_overrun (frame_overrun)
  );

  always #5 clk_25mHz = ~clk_25mHz;

  function automatic logic [15:0] lfsr_next(logic [15:0] v);
    int fb;
    fb = ((v >> 15) ^ (v >> 13) ^ (v >> 12) ^ (v >> 10)) & 1;
    return 16'((int'(v) << 1) | fb);
  endfunction

  // Sequence position of the design's LFSR, counted from reset.
  always @(posedge clk_25mHz or posedge reset) begin
    if (reset) m_lfsr <= 16'hACE1;
    else       m_lfsr <= lfsr_next(m_lfsr);
  end

  task automatic check(input string tag, input longint got, input longint exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int vel(int t);
    if (t >= -4 && t <= 4) return 0;
    if (t >= 0) return t / 8;
    return -((-t + 7) / 8);
  endfunction

  function automatic int clampi(int v, int lo, int hi);
    return (v < lo) ? lo : (v > hi) ? hi : v;
  endfunction

  function automatic bit overlaps(int ax, int ay, int bx, int by);
    int dx, dy;
    dx = (ax > bx) ? ax - bx : bx - ax;
    dy = (ay > by) ? ay - by : by - ay;
    return (dx < 55) && (dy < 55);
  endfunction

  task automatic model_reset();
    mpx = 320; mpy = 240; mtx = 160; mty = 120; mscore = 0;
  endtask

  task automatic do_reset();
    @(negedge clk_25mHz);
    reset = 1'b1;
    @(negedge clk_25mHz);
    @(negedge clk_25mHz);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic run_frame(input int tx, input int ty, input bit extra, input bit rej);
    int nx, ny, etx, ety, escore, ebusy, cx, cy;
    bit ehit, placed, done;
    logic [15:0] l, lv;
    logic [11:0] tv;
    int seen_busy, seen_hit, seen_ovr, hit_k3;
    nx = clampi(mpx + vel(tx), 25, 614);
    ny = clampi(mpy + vel(ty), 25, 454);
    ehit = overlaps(nx, ny, mtx, mty);
    etx = mtx; ety = mty; escore = mscore; ebusy = 3;
    if (ehit) begin
      escore = (mscore == 65535) ? 65535 : mscore + 1;
      l = m_lfsr;
      repeat (4) l = lfsr_next(l);
      placed = 1'b0;
      for (int i = 0; i < 15 && !placed; i++) begin
        lv = rej ? 16'hFFFF : l;
        cx = int'(lv) & 1023;
        cy = ((int'(lv) >> 8) & 255) + (int'(lv) & 1);
        if (cx >= 30 && cx <= 609 && cy >= 30 && cy <= 449 && !overlaps(cx, cy, nx, ny)) begin
          etx = cx; ety = cy; ebusy = 4 + i; placed = 1'b1;
        end
        l = lfsr_next(l);
      end
      if (!placed) begin
        etx = clampi(639 - nx, 30, 609);
        ety = clampi(479 - ny, 30, 449);
        ebusy = 18;
      end
    end
    if (rej) force dut.lfsr_q = 16'hFFFF;
    tv = tx[11:0]; tilt_x = tv;
    tv = ty[11:0]; tilt_y = tv;
    frame_tick = 1'b1;
    seen_busy = 0; seen_hit = 0; seen_ovr = 0; hit_k3 = 0; done = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(posedge clk_25mHz);
      @(negedge clk_25mHz);
      frame_tick = extra && (k == 0 || k == ebusy - 1);
      if (k == 1) check("player_x_before_clamp", player_x, mpx);
      if (k == 2) begin
        check("player_x", player_x, nx);
        check("player_y", player_y, ny);
      end
      if (k == 3) hit_k3 = int'(hit);
      seen_hit += int'(hit);
      seen_ovr += int'(frame_overrun);
      if (busy) seen_busy++;
      else      done = 1'b1;
    end
    frame_tick = 1'b0;
    if (rej) release dut.lfsr_q;
    if (!done) check("busy_timeout", 0, 1);
    check("busy_cycles", seen_busy, ebusy);
    check("hit_pulses", seen_hit, int'(ehit));
    check("hit_timing", hit_k3, int'(ehit));
    check("overrun_pulses", seen_ovr, extra ? 2 : 0);
    check("target_x", target_x, etx);
    check("target_y", target_y, ety);
    check("score", score, escore);
    mpx = nx; mpy = ny; mtx = etx; mty = ety; mscore = escore;
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk_25mHz);
    reset = 1'b0;
    check("rst_player_x", player_x, 320);
    check("rst_player_y", player_y, 240);
    check("rst_target_x", target_x, 160);
    check("rst_target_y", target_y, 120);
    check("rst_score", score, 0);
    check("rst_hit", hit, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", frame_overrun, 0);

    // Directed walk: deadzone edges, clamps on both axes, overrun, then a hit.
    run_frame(80, -3, 1'b0, 1'b0);
    run_frame(2047, 0, 1'b0, 1'b0);
    run_frame(200, 0, 1'b0, 1'b0);
    run_frame(2047, 0, 1'b0, 1'b0);
    run_frame(0, -1680, 1'b0, 1'b0);
    run_frame(0, -2048, 1'b0, 1'b0);
    run_frame(-5, -4, 1'b0, 1'b0);
    run_frame(4, 5, 1'b0, 1'b0);
    run_frame(-2048, 1000, 1'b1, 1'b0);
    run_frame(-1256, 0, 1'b0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      int rx, ry;
      if ($urandom_range(0, 3) == 0) begin
        rx = int'($urandom_range(0, 16)) - 8;
        ry = int'($urandom_range(0, 16)) - 8;
      end else begin
        rx = int'($urandom_range(0, 4095)) - 2048;
        ry = int'($urandom_range(0, 4095)) - 2048;
      end
      repeat ($urandom_range(0, 3)) @(negedge clk_25mHz);
      run_frame(rx, ry, $urandom_range(0, 4) == 0, 1'b0);
    end

    // Every candidate rejected: mirrored fallback placement.
    do_reset();
    run_frame(-960, -720, 1'b0, 1'b1);

    // Reset while relocating.
    do_reset();
    force dut.lfsr_q = 16'hFFFF;
    tilt_x = 12'hC40;
    tilt_y = 12'hD30;
    frame_tick = 1'b1;
    @(negedge clk_25mHz);
    frame_tick = 1'b0;
    repeat (5) @(negedge clk_25mHz);
    check("busy_in_relocate", busy, 1);
    reset = 1'b1;
    #1;
    check("abort_player_x", player_x, 320);
    check("abort_player_y", player_y, 240);
    check("abort_target_x", target_x, 160);
    check("abort_target_y", target_y, 120);
    check("abort_score", score, 0);
    check("abort_busy", busy, 0);
    @(negedge clk_25mHz);
    reset = 1'b0;
    release dut.lfsr_q;
    model_reset();
    @(negedge clk_25mHz);
    check("post_abort_busy", busy, 0);
    check("post_abort_player_x", player_x, 320);

    // Saturating score.
    do_reset();
    force dut.score_q = 16'hFFFF;
    mscore = 65535;
    run_frame(-960, -720, 1'b0, 1'b0);
    release dut.score_q;
    @(negedge clk_25mHz);
    check("score_saturated", score, 65535);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
